mem_port_arbiter: RTL

// - Shares one single-port 32-bit memory between instruction fetch and the load/store path.
// - Sits between the core (PC/fetch and load/store decode) and the memory.
// - One transaction outstanding at a time.
// - Generates byte enables and lane-aligns read data for lb/lh/lw/lbu/lhu/sb/sh/sw.

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: core fetch port, core data port and memory port.
// master = arbiter side, slave = core/memory environment side.
interface mem_port_arbiter_if #(parameter int ADDR_W = 32);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              d_req;
    logic              d_we;
    logic [2:0]        d_funct3;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_done;
    logic              d_err;
    logic [31:0]       d_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata,
               mem_ready, mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_done, d_err, d_rdata,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata,
               mem_ready, mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_done, d_err, d_rdata,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port 32-bit memory between fetch and load/store, one access at a time.
// Define RR_ARB_EN for round-robin arbitration; default is data-over-fetch fixed priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 32
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.master bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              own_d_q, own_d_d;      // 1 = data path owns the transaction
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic              d_done_q, d_done_d;
    logic              d_err_q, d_err_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
`ifdef RR_ARB_EN
    logic              last_d_q, last_d_d;
`endif

    logic        idle, pick_d, pick_if, mis, rd_done;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, shifted, load_ext;

    assign idle = (state_q == S_IDLE);

`ifdef RR_ARB_EN
    assign pick_d = bus.d_req & (~bus.if_req | ~last_d_q);
`else
    assign pick_d = bus.d_req;
`endif
    assign pick_if = bus.if_req & ~pick_d;

    // Size comes from funct3[1:0]; the unused encodings fall through to word.
    always_comb begin
        mis      = 1'b0;
        st_be    = 4'b1111;
        st_wdata = bus.d_wdata;
        case (bus.d_funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << bus.d_addr[1:0];
                st_wdata = {4{bus.d_wdata[7:0]}};
            end
            2'b01: begin
                mis      = bus.d_addr[0];
                st_be    = 4'b0011 << bus.d_addr[1:0];
                st_wdata = {2{bus.d_wdata[15:0]}};
            end
            default: mis = |bus.d_addr[1:0];
        endcase
    end

    always_comb begin
        shifted = bus.mem_rdata >> {addr_q[1:0], 3'b000};
        case (f3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    assign rd_done = ((state_q == S_REQ) & bus.mem_ready & ~we_q & bus.mem_rvalid) |
                     ((state_q == S_RESP) & bus.mem_rvalid);

    always_comb begin
        state_d     = state_q;
        own_d_d     = own_d_q;
        addr_d      = addr_q;
        we_d        = we_q;
        f3_d        = f3_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_done_d    = 1'b0;
        d_err_d     = 1'b0;
        d_rdata_d   = d_rdata_q;
`ifdef RR_ARB_EN
        last_d_d    = last_d_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_d) begin
                    own_d_d = 1'b1;
                    addr_d  = bus.d_addr;
                    we_d    = bus.d_we;
                    f3_d    = bus.d_funct3;
                    be_d    = bus.d_we ? st_be : 4'b1111;
                    wdata_d = bus.d_we ? st_wdata : 32'd0;
`ifdef RR_ARB_EN
                    last_d_d = 1'b1;
`endif
                    if (mis) begin
                        state_d  = S_ERR;
                        d_done_d = 1'b1;
                        d_err_d  = 1'b1;
                    end else begin
                        state_d  = S_REQ;
                    end
                end else if (pick_if) begin
                    own_d_d = 1'b0;
                    addr_d  = bus.if_addr;
                    we_d    = 1'b0;
                    f3_d    = 3'b010;
                    be_d    = 4'b1111;
                    wdata_d = 32'd0;
                    state_d = S_REQ;
`ifdef RR_ARB_EN
                    last_d_d = 1'b0;
`endif
                end
            end
            S_REQ: begin
                if (bus.mem_ready) begin
                    if (we_q) begin
                        state_d  = S_IDLE;
                        d_done_d = 1'b1;
                    end else begin
                        state_d  = bus.mem_rvalid ? S_IDLE : S_RESP;
                    end
                end
            end
            S_RESP:  if (bus.mem_rvalid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (rd_done) begin
            if (own_d_q) begin
                d_done_d  = 1'b1;
                d_rdata_d = load_ext;
            end else begin
                if_rvalid_d = 1'b1;
                if_rdata_d  = bus.mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            own_d_q     <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            f3_q        <= 3'd0;
            be_q        <= 4'd0;
            wdata_q     <= 32'd0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= 32'd0;
            d_done_q    <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= 32'd0;
`ifdef RR_ARB_EN
            last_d_q    <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            own_d_q     <= own_d_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_done_q    <= d_done_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
`ifdef RR_ARB_EN
            last_d_q    <= last_d_d;
`endif
        end
    end

    assign bus.if_gnt    = idle & pick_if;
    assign bus.d_gnt     = idle & pick_d;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_done    = d_done_q;
    assign bus.d_err     = d_err_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_req   = (state_q == S_REQ);
    assign bus.mem_we    = bus.mem_req & we_q;
    assign bus.mem_addr  = bus.mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus.mem_be    = bus.mem_req ? be_q : 4'd0;
    assign bus.mem_wdata = bus.mem_req ? wdata_q : 32'd0;
endmodule
